// File: rtl/alu_exec.sv
// RV32I execute-stage ALU with integrated opcode/funct3/bit30 decoder and a registered result.
// Optional sticky illegal-op flag (illegal_q) is built when ALU_ILLEGAL_FLAG_EN is defined.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct,
  input  logic            add_rshift_type,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [3:0]      ALUop,
  output logic [XLEN-1:0] Out,
`ifdef ALU_ILLEGAL_FLAG_EN
  output logic            illegal_q,
`endif
  output logic [XLEN-1:0] Out_q
);

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_SLT     = 4'd5;
  localparam logic [3:0] OP_SLTU    = 4'd6;
  localparam logic [3:0] OP_SLL     = 4'd7;
  localparam logic [3:0] OP_SRL     = 4'd8;
  localparam logic [3:0] OP_SRA     = 4'd9;
  localparam logic [3:0] OP_COPY_B  = 4'd10;
  localparam logic [3:0] OP_INVALID = 4'd15;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [4:0] shamt;
  logic       slt_bit;
  logic       sltu_bit;

  // R-type and I-type share the funct3 table; only funct3=000 differs (no SUBI).
  always_comb begin
    ALUop = OP_INVALID;
    case (opcode)
      OPC_LUI: ALUop = OP_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: ALUop = OP_ADD;
      OPC_OP, OPC_OP_IMM: begin
        case (funct)
          3'b000:  ALUop = (opcode == OPC_OP && add_rshift_type) ? OP_SUB : OP_ADD;
          3'b001:  ALUop = OP_SLL;
          3'b010:  ALUop = OP_SLT;
          3'b011:  ALUop = OP_SLTU;
          3'b100:  ALUop = OP_XOR;
          3'b101:  ALUop = add_rshift_type ? OP_SRA : OP_SRL;
          3'b110:  ALUop = OP_OR;
          3'b111:  ALUop = OP_AND;
          default: ALUop = OP_INVALID;
        endcase
      end
      default: ALUop = OP_INVALID;
    endcase
  end

  assign shamt    = B[4:0];
  assign slt_bit  = $signed(A) < $signed(B);
  assign sltu_bit = A < B;

  always_comb begin
    Out = '0;
    case (ALUop)
      OP_ADD:    Out = A + B;
      OP_SUB:    Out = A - B;
      OP_AND:    Out = A & B;
      OP_OR:     Out = A | B;
      OP_XOR:    Out = A ^ B;
      OP_SLT:    Out = {{(XLEN-1){1'b0}}, slt_bit};
      OP_SLTU:   Out = {{(XLEN-1){1'b0}}, sltu_bit};
      OP_SLL:    Out = A << shamt;
      OP_SRL:    Out = A >> shamt;
      OP_SRA:    Out = $signed(A) >>> shamt;
      OP_COPY_B: Out = B;
      default:   Out = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Out_q <= '0;
    end else begin
      Out_q <= Out;
    end
  end

`ifdef ALU_ILLEGAL_FLAG_EN
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      illegal_q <= 1'b0;
    end else if (ALUop == OP_INVALID) begin
      illegal_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: combinational checks at drive time, registered result checked
// against a queue of expected values popped one edge later.
module tb_alu_exec;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic [31:0] Out_q;
`ifdef ALU_ILLEGAL_FLAG_EN
  logic        illegal_q;
  logic        exp_ill;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_exec #(.XLEN(32)) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .opcode(opcode),
    .funct(funct),
    .add_rshift_type(add_rshift_type),
    .A(A),
    .B(B),
    .ALUop(ALUop),
    .Out(Out),
`ifdef ALU_ILLEGAL_FLAG_EN
    .illegal_q(illegal_q),
`endif
    .Out_q(Out_q)
  );

  always #5 Clock = ~Clock;

  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f, input logic b30,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] eop, input logic [31:0] eout, input logic rst_n);
    logic [31:0] eq;
    opcode = op; funct = f; add_rshift_type = b30; A = a; B = b; Reset_n = rst_n;
    #2;
    checks++;
    assert (ALUop === eop) else begin
      errors++;
      $error("FAIL %s aluop observed=%0d expected=%0d", tag, ALUop, eop);
    end
    checks++;
    assert (Out === eout) else begin
      errors++;
      $error("FAIL %s out observed=%h expected=%h", tag, Out, eout);
    end
    exp_q.push_back(rst_n ? eout : 32'h0);
`ifdef ALU_ILLEGAL_FLAG_EN
    if (!rst_n) exp_ill = 1'b0;
    else if (eop == 4'd15) exp_ill = 1'b1;
`endif
    @(posedge Clock);
    #1;
    eq = exp_q.pop_front();
    checks++;
    assert (Out_q === eq) else begin
      errors++;
      $error("FAIL %s out_q observed=%h expected=%h", tag, Out_q, eq);
    end
`ifdef ALU_ILLEGAL_FLAG_EN
    checks++;
    assert (illegal_q === exp_ill) else begin
      errors++;
      $error("FAIL %s illegal_q observed=%b expected=%b", tag, illegal_q, exp_ill);
    end
`endif
    $display("step %-10s op=%b f=%b b30=%b A=%h B=%h ALUop=%0d Out=%h Out_q=%h",
             tag, op, f, b30, a, b, ALUop, Out, Out_q);
  endtask

  initial begin
    logic [6:0]  ops[7];
    logic [31:0] ra;
    logic [31:0] rb;
    ops = '{7'b0110111, 7'b0010111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111};

    opcode = 7'b0; funct = 3'b0; add_rshift_type = 1'b0; A = 32'h1234; B = 32'h5678; Reset_n = 1'b0;
`ifdef ALU_ILLEGAL_FLAG_EN
    exp_ill = 1'b0;
`endif
    @(posedge Clock);
    #1;
    checks++;
    assert (Out_q === 32'h0) else begin
      errors++;
      $error("FAIL reset out_q observed=%h expected=%h", Out_q, 32'h0);
    end
`ifdef ALU_ILLEGAL_FLAG_EN
    checks++;
    assert (illegal_q === 1'b0) else begin
      errors++;
      $error("FAIL reset illegal_q observed=%b expected=0", illegal_q);
    end
`endif

    // LUI copies B; the address-forming opcodes all add, regardless of funct/bit30.
    for (int i = 0; i < 14; i++) begin
      ra = $urandom() | 32'h8000_0000;
      rb = {16'hFFFF, 1'b1, 15'($urandom_range(0, 32767))};
      if (ops[i % 7] == 7'b0110111)
        step("lui", ops[i % 7], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, 4'd10, rb, 1'b1);
      else
        step("addr_add", ops[i % 7], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ra, rb, 4'd0, ra + rb, 1'b1);
    end

    step("r_add",   7'b0110011, 3'b000, 1'b0, 32'd10, 32'd0, 4'd0, 32'd10, 1'b1);
    step("r_sub",   7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 1'b1);
    step("slt_pos", 7'b0110011, 3'b010, 1'b0, 32'd10, 32'hFFFF_FFFF, 4'd5, 32'd0, 1'b1);
    step("sltu",    7'b0110011, 3'b011, 1'b0, 32'd10, 32'hFFFF_FFFF, 4'd6, 32'd1, 1'b1);
    step("slt_neg", 7'b0010011, 3'b010, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'd5, 32'd1, 1'b1);
    step("sll",     7'b0110011, 3'b001, 1'b0, 32'h8000_0010, 32'h0000_0024, 4'd7, 32'h0000_0100, 1'b1);
    step("srl",     7'b0110011, 3'b101, 1'b0, 32'h8000_0010, 32'h0000_0024, 4'd8, 32'h0800_0001, 1'b1);
    step("sra",     7'b0110011, 3'b101, 1'b1, 32'h8000_0010, 32'h0000_0024, 4'd9, 32'hF800_0001, 1'b1);
    step("srai",    7'b0010011, 3'b101, 1'b1, 32'h8000_0010, 32'hFFFF_FFE0, 4'd9, 32'h8000_0010, 1'b1);
    step("xor",     7'b0110011, 3'b100, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd4, 32'hFF00_EDCB, 1'b1);
    step("or",      7'b0010011, 3'b110, 1'b0, 32'hF000_0001, 32'h0000_0F10, 4'd3, 32'hF000_0F11, 1'b1);
    step("and",     7'b0110011, 3'b111, 1'b1, 32'hF0F0_F0F0, 32'hFF00_0FF0, 4'd2, 32'hF000_00F0, 1'b1);
    step("addi_b30", 7'b0010011, 3'b000, 1'b1, 32'd3, 32'd4, 4'd0, 32'd7, 1'b1);
    step("add_wrap", 7'b0110011, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd2, 4'd0, 32'd1, 1'b1);
    step("invalid", 7'b0000000, 3'b000, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd15, 32'd0, 1'b1);
    step("after_inv", 7'b0110011, 3'b000, 1'b0, 32'd100, 32'd23, 4'd0, 32'd123, 1'b1);
    step("mid_reset", 7'b0110011, 3'b110, 1'b0, 32'hAAAA_0000, 32'h0000_5555, 4'd3, 32'hAAAA_5555, 1'b0);
    step("post_rst", 7'b0110111, 3'b000, 1'b0, 32'h0, 32'hDEAD_B000, 4'd10, 32'hDEAD_B000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
